// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU vs load unit) feeding one register-file write port, plus a pending-write scoreboard.
// Grants are combinational; the write port is registered one cycle after the transfer. A losing requester waits with valid held.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic                    I_clk,
    input  logic                    I_rst_n,
    input  logic                    I_en,
    input  logic                    I_aluValid,
    input  logic [SEL_W-1:0]        I_aluSel,
    input  logic [DATA_W-1:0]       I_aluData,
    output logic                    o_aluReady,
    input  logic                    I_memValid,
    input  logic [SEL_W-1:0]        I_memSel,
    input  logic [DATA_W-1:0]       I_memData,
    output logic                    o_memReady,
    input  logic                    I_issueValid,
    input  logic [SEL_W-1:0]        I_issueSel,
    input  logic [SEL_W-1:0]        I_chkSelA,
    input  logic [SEL_W-1:0]        I_chkSelB,
    output logic                    o_hazardA,
    output logic                    o_hazardB,
    output logic                    o_we,
    output logic [SEL_W-1:0]        o_selD,
    output logic [DATA_W-1:0]       o_dataD,
    output logic [(2**SEL_W)-1:0]   o_busy
);

    localparam int NREG = 2**SEL_W;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } pri_e;

    pri_e              pri_q, pri_d;
    logic              alu_gnt, mem_gnt, xfer;
    logic [SEL_W-1:0]  gnt_sel;
    logic [DATA_W-1:0] gnt_data;
    logic              we_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] data_q;
    logic [NREG-1:0]   busy_q, busy_d;

    // A lone requester always wins; on contention the priority pointer decides.
    always_comb begin
        alu_gnt  = I_en & I_aluValid & (~I_memValid | (pri_q == PRI_ALU));
        mem_gnt  = I_en & I_memValid & (~I_aluValid | (pri_q == PRI_MEM));
        xfer     = alu_gnt | mem_gnt;
        gnt_sel  = alu_gnt ? I_aluSel  : I_memSel;
        gnt_data = alu_gnt ? I_aluData : I_memData;
    end

    always_comb begin
        pri_d = pri_q;
        if (alu_gnt) begin
            pri_d = PRI_MEM;
        end else if (mem_gnt) begin
            pri_d = PRI_ALU;
        end
    end

    // Set is applied after clear so a fresh issue to the register being written keeps it pending.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[gnt_sel] = 1'b0;
        end
        if (I_en && I_issueValid) begin
            busy_d[I_issueSel] = 1'b1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pri_q  <= PRI_ALU;
            busy_q <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            pri_q  <= pri_d;
            busy_q <= busy_d;
            we_q   <= xfer;
            if (xfer) begin
                sel_q  <= gnt_sel;
                data_q <= gnt_data;
            end
        end
    end

    assign o_aluReady = alu_gnt;
    assign o_memReady = mem_gnt;
    assign o_we       = we_q;
    assign o_selD     = sel_q;
    assign o_dataD    = data_q;
    assign o_busy     = busy_q;

    // The committing write still counts as a hazard until the register file has absorbed it.
    assign o_hazardA = busy_q[I_chkSelA] | (we_q & (sel_q == I_chkSelA));
    assign o_hazardB = busy_q[I_chkSelB] | (we_q & (sel_q == I_chkSelB));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle scoreboard model plus hand-computed literal checks.
module tb_regfile_wb_arbiter;

    logic        clk, rst_n, en;
    logic        alu_v, mem_v, iss_v;
    logic [2:0]  alu_sel, mem_sel, iss_sel, chk_a, chk_b;
    logic [15:0] alu_dat, mem_dat;
    logic        alu_rdy, mem_rdy, haz_a, haz_b, we;
    logic [2:0]  sel_d;
    logic [15:0] dat_d;
    logic [7:0]  busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    regfile_wb_arbiter dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en),
        .I_aluValid(alu_v), .I_aluSel(alu_sel), .I_aluData(alu_dat), .o_aluReady(alu_rdy),
        .I_memValid(mem_v), .I_memSel(mem_sel), .I_memData(mem_dat), .o_memReady(mem_rdy),
        .I_issueValid(iss_v), .I_issueSel(iss_sel),
        .I_chkSelA(chk_a), .I_chkSelB(chk_b), .o_hazardA(haz_a), .o_hazardB(haz_b),
        .o_we(we), .o_selD(sel_d), .o_dataD(dat_d), .o_busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending set, who won last, and the last committed write.
    bit          m_last_was_mem;
    bit          m_we;
    logic [2:0]  m_sel;
    logic [15:0] m_dat;
    bit          m_pend [8];

    wire exp_alu = en && alu_v && (!mem_v || m_last_was_mem);
    wire exp_mem = en && mem_v && (!alu_v || !m_last_was_mem);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last_was_mem <= 1'b1;
            m_we  <= 1'b0;
            m_sel <= '0;
            m_dat <= '0;
            for (int r = 0; r < 8; r++) m_pend[r] <= 1'b0;
        end else begin
            m_we <= exp_alu || exp_mem;
            if (exp_alu) begin
                m_sel <= alu_sel; m_dat <= alu_dat; m_last_was_mem <= 1'b0;
            end else if (exp_mem) begin
                m_sel <= mem_sel; m_dat <= mem_dat; m_last_was_mem <= 1'b1;
            end
            for (int r = 0; r < 8; r++) begin
                if (en && iss_v && iss_sel == 3'(r))
                    m_pend[r] <= 1'b1;
                else if (exp_alu && alu_sel == 3'(r))
                    m_pend[r] <= 1'b0;
                else if (exp_mem && mem_sel == 3'(r))
                    m_pend[r] <= 1'b0;
            end
        end
    end

    function automatic logic [7:0] m_busy_vec();
        logic [7:0] v;
        for (int r = 0; r < 8; r++) v[r] = m_pend[r];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model aluReady", {31'b0, alu_rdy}, {31'b0, exp_alu});
            chk("model memReady", {31'b0, mem_rdy}, {31'b0, exp_mem});
            chk("model we", {31'b0, we}, {31'b0, m_we});
            chk("model selD", {29'b0, sel_d}, {29'b0, m_sel});
            chk("model dataD", {16'b0, dat_d}, {16'b0, m_dat});
            chk("model busy", {24'b0, busy}, {24'b0, m_busy_vec()});
            chk("model hazardA", {31'b0, haz_a}, {31'b0, m_pend[chk_a] || (m_we && m_sel == chk_a)});
            chk("model hazardB", {31'b0, haz_b}, {31'b0, m_pend[chk_b] || (m_we && m_sel == chk_b)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_v = 0; mem_v = 0; iss_v = 0;
    endtask

    initial begin
        rst_n = 0; en = 1; idle();
        alu_sel = 0; mem_sel = 0; iss_sel = 0; chk_a = 0; chk_b = 0;
        alu_dat = 0; mem_dat = 0;
        tick(); tick();
        chk("rst we", {31'b0, we}, 32'd0);
        chk("rst selD", {29'b0, sel_d}, 32'd0);
        chk("rst dataD", {16'b0, dat_d}, 32'd0);
        chk("rst busy", {24'b0, busy}, 32'd0);
        rst_n = 1; chk_en = 1;

        // Single ALU request
        tick();
        alu_v = 1; alu_sel = 3'd2; alu_dat = 16'h2222;
        #1;
        chk("single aluReady", {31'b0, alu_rdy}, 32'd1);
        chk("single memReady", {31'b0, mem_rdy}, 32'd0);
        tick(); idle();
        chk("single we", {31'b0, we}, 32'd1);
        chk("single selD", {29'b0, sel_d}, 32'd2);
        chk("single dataD", {16'b0, dat_d}, 32'h2222);
        tick();
        chk("single we drop", {31'b0, we}, 32'd0);
        chk("single selD hold", {29'b0, sel_d}, 32'd2);

        // Reset then contention: ALU, MEM, ALU, MEM
        rst_n = 0; tick(); rst_n = 1;
        alu_v = 1; alu_sel = 3'd1; alu_dat = 16'h1111;
        mem_v = 1; mem_sel = 3'd3; mem_dat = 16'h3333;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr aluReady", {31'b0, alu_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr memReady", {31'b0, mem_rdy}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("rr we", {31'b0, we}, 32'd1);
            chk("rr selD", {29'b0, sel_d}, (i % 2 == 0) ? 32'd1 : 32'd3);
            chk("rr dataD", {16'b0, dat_d}, (i % 2 == 0) ? 32'h1111 : 32'h3333);
        end
        idle();

        // Issue/hazard/clear on register 4
        iss_v = 1; iss_sel = 3'd4;
        tick(); idle(); chk_a = 3'd4;
        #1;
        chk("haz pending", {31'b0, haz_a}, 32'd1);
        chk("haz busy4 set", {31'b0, busy[4]}, 32'd1);
        mem_v = 1; mem_sel = 3'd4; mem_dat = 16'h4444;
        #1;
        chk("haz memReady", {31'b0, mem_rdy}, 32'd1);
        tick(); idle();
        chk("haz during we", {31'b0, haz_a}, 32'd1);
        chk("haz busy4 clr", {31'b0, busy[4]}, 32'd0);
        tick();
        chk("haz after we", {31'b0, haz_a}, 32'd0);

        // Set beats clear on register 5
        iss_v = 1; iss_sel = 3'd5;
        tick();
        alu_v = 1; alu_sel = 3'd5; alu_dat = 16'h5555;
        #1;
        chk("setwin aluReady", {31'b0, alu_rdy}, 32'd1);
        tick(); idle();
        chk("setwin busy5", {31'b0, busy[5]}, 32'd1);
        chk("setwin selD", {29'b0, sel_d}, 32'd5);

        // Disabled: nothing moves
        tick();
        en = 0; alu_v = 1; mem_v = 1; iss_v = 1; iss_sel = 3'd6;
        #1;
        chk("dis aluReady", {31'b0, alu_rdy}, 32'd0);
        chk("dis memReady", {31'b0, mem_rdy}, 32'd0);
        tick();
        chk("dis we", {31'b0, we}, 32'd0);
        chk("dis busy", {24'b0, busy}, 32'h20);
        en = 1; idle();

        // Mixed directed sequence, checked by the model every cycle
        for (int i = 0; i < 16; i++) begin
            tick();
            en      = (i != 6);
            alu_v   = (i % 3 != 2);
            mem_v   = (i % 4 < 2);
            alu_sel = 3'(i);
            mem_sel = 3'(7 - i);
            alu_dat = 16'(16'h0A00 + i);
            mem_dat = 16'(16'hB000 + i);
            iss_v   = (i % 2 == 0);
            iss_sel = 3'(i * 3);
            chk_a   = 3'(i + 1);
            chk_b   = 3'(i * 5);
        end
        tick(); idle();

        // Async reset right after a transfer
        alu_v = 1; alu_sel = 3'd7; alu_dat = 16'h7777;
        tick(); idle();
        chk("arst pre we", {31'b0, we}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("arst we", {31'b0, we}, 32'd0);
        chk("arst selD", {29'b0, sel_d}, 32'd0);
        chk("arst dataD", {16'b0, dat_d}, 32'd0);
        chk("arst busy", {24'b0, busy}, 32'd0);
        tick(); rst_n = 1;
        tick();
        chk("post-rst we", {31'b0, we}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
